// File: rtl/fec_pkg.sv
// Shared types and instance constants for the DL FEC encode/decode paths.
package fec_pkg;

    typedef enum logic [1:0] {
        DS_CLEAN     = 2'd0,
        DS_CORRECTED = 2'd1,
        DS_UNCORR    = 2'd2,
        DS_CRC_FAIL  = 2'd3
    } dec_status_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYND = 3'd1,
        ST_CORR = 3'd2,
        ST_CRC  = 3'd3,
        ST_DONE = 3'd4
    } dec_state_e;

    // Payload instance: 8x8 block, CRC-8
    localparam int         DEC0_WIDTH     = 8;
    localparam int         DEC0_DEPTH     = 8;
    localparam int         DEC0_CRC_WIDTH = 8;
    localparam logic [7:0] DEC0_POLY      = 8'h07;
    localparam logic [7:0] DEC0_SEED      = 8'h00;
    localparam int         DEC0_XOR_OPS   = 8;

    // Header instance: 4x4 block, CRC-4
    localparam int         DEC1_WIDTH     = 4;
    localparam int         DEC1_DEPTH     = 4;
    localparam int         DEC1_CRC_WIDTH = 4;
    localparam logic [3:0] DEC1_POLY      = 4'h3;
    localparam logic [3:0] DEC1_SEED      = 4'h0;
    localparam int         DEC1_XOR_OPS   = 4;

endpackage

// File: rtl/fec_syndrome_acc.sv
// Row/column syndrome accumulator; reports zero / single-bit syndromes
// and the position of the set bit.
module fec_syndrome_acc
    import fec_pkg::*;
#(
    parameter int WIDTH = DEC0_WIDTH,
    parameter int DEPTH = DEC0_DEPTH,
    localparam int RW = $clog2(DEPTH),
    localparam int CI = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             last,
    input  logic [RW-1:0]    row_idx,
    input  logic [WIDTH-1:0] row,
    input  logic             row_p,
    input  logic [WIDTH-1:0] col_p,
    output logic             rs_zero,
    output logic             rs_one,
    output logic             cs_zero,
    output logic             cs_one,
    output logic [RW-1:0]    r_idx,
    output logic [CI-1:0]    c_idx
);
    logic [DEPTH-1:0] rs_q, rs_d;
    logic [WIDTH-1:0] cs_q, cs_d;

    always_comb begin
        rs_d = rs_q;
        cs_d = cs_q;
        if (clr) begin
            rs_d = '0;
            cs_d = '0;
        end else if (en) begin
            rs_d[row_idx] = ^row ^ row_p;
            // column parity folds in together with the last row
            cs_d = cs_q ^ row ^ (last ? col_p : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_q <= '0;
            cs_q <= '0;
        end else begin
            rs_q <= rs_d;
            cs_q <= cs_d;
        end
    end

    assign rs_zero = ~|rs_q;
    assign cs_zero = ~|cs_q;
    assign rs_one  = ($countones(rs_q) == 1);
    assign cs_one  = ($countones(cs_q) == 1);

    always_comb begin
        r_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (rs_q[i]) r_idx = RW'(i);
    end

    always_comb begin
        c_idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (cs_q[i]) c_idx = CI'(i);
    end

endmodule

// File: rtl/dl_fec_dec_engine.sv
// Receive-side 2-D parity FEC decoder: single-bit correction followed
// by a CRC re-check of the corrected payload.
module dl_fec_dec_engine
    import fec_pkg::*;
#(
    parameter int WIDTH     = DEC0_WIDTH,
    parameter int DEPTH     = DEC0_DEPTH,
    parameter int CRC_WIDTH = DEC0_CRC_WIDTH,
    parameter logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(DEC0_POLY),
    parameter logic [CRC_WIDTH-1:0] SEED = CRC_WIDTH'(DEC0_SEED),
    parameter int XOR_OPS   = DEC0_XOR_OPS,
    localparam int DW = WIDTH * DEPTH,
    localparam int PW = DW - CRC_WIDTH,
    localparam int RW = $clog2(DEPTH),
    localparam int CI = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW-1:0]    blk_in,
    input  logic [DEPTH-1:0] row_p_in,
    input  logic [WIDTH-1:0] col_p_in,
    output logic             busy,
    output logic             done,
    output logic [PW-1:0]    payload_out,
    output logic [1:0]       status,
    output logic [RW-1:0]    err_row,
    output logic [CI-1:0]    err_col
);
    localparam int NCH  = PW / XOR_OPS;
    localparam int CNTW = $clog2(((DEPTH > NCH) ? DEPTH : NCH) + 1);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_SYND = ST_SYND;
    localparam logic [2:0] S_CORR = ST_CORR;
    localparam logic [2:0] S_CRC  = ST_CRC;
    localparam logic [2:0] S_DONE = ST_DONE;

    if (PW % XOR_OPS != 0) begin : g_bad_xor_ops
        $error("XOR_OPS must divide the payload width");
    end

    logic [2:0]           state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]        blk_q, blk_d;
    logic [DEPTH-1:0]     rp_q, rp_d;
    logic [WIDTH-1:0]     cp_q, cp_d;
    logic [CRC_WIDTH-1:0] crc_q, crc_d;
    logic [1:0]           stat_q, stat_d;
    logic [RW-1:0]        er_q, er_d;
    logic [CI-1:0]        ec_q, ec_d;
    logic [PW-1:0]        pay_q, pay_d;
    logic [1:0]           status_q, status_d;
    logic [RW-1:0]        err_row_q, err_row_d;
    logic [CI-1:0]        err_col_q, err_col_d;

    logic                 acc_clr, acc_en, acc_last;
    logic                 rs_zero, rs_one, cs_zero, cs_one;
    logic [RW-1:0]        r_idx, row_sel;
    logic [CI-1:0]        c_idx;
    logic [DW-1:0]        rsh;
    logic [WIDTH-1:0]     row;
    logic [PW-1:0]        psh;
    logic [XOR_OPS-1:0]   chunk;
    logic [CRC_WIDTH-1:0] crc_nx;
    logic                 fb, crc_bad, fixable;

    assign row_sel  = RW'(cnt_q);
    assign acc_last = (cnt_q == CNTW'(DEPTH - 1));

    always_comb begin
        rsh = blk_q >> (int'(cnt_q) * WIDTH);
        row = rsh[WIDTH-1:0];
    end

    fec_syndrome_acc #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_synd (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc_clr),
        .en      (acc_en),
        .last    (acc_last),
        .row_idx (row_sel),
        .row     (row),
        .row_p   (rp_q[row_sel]),
        .col_p   (cp_q),
        .rs_zero (rs_zero),
        .rs_one  (rs_one),
        .cs_zero (cs_zero),
        .cs_one  (cs_one),
        .r_idx   (r_idx),
        .c_idx   (c_idx)
    );

    // Bit-serial LFSR, payload MSB first, XOR_OPS bits per cycle
    always_comb begin
        psh    = blk_q[PW-1:0] << (int'(cnt_q) * XOR_OPS);
        chunk  = psh[PW-1 -: XOR_OPS];
        crc_nx = crc_q;
        fb     = 1'b0;
        for (int i = 0; i < XOR_OPS; i++) begin
            fb     = crc_nx[CRC_WIDTH-1] ^ chunk[XOR_OPS-1-i];
            crc_nx = {crc_nx[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    assign crc_bad = (crc_nx != blk_q[DW-1 -: CRC_WIDTH]);
    assign fixable = (rs_zero || rs_one) && (cs_zero || cs_one);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blk_d     = blk_q;
        rp_d      = rp_q;
        cp_d      = cp_q;
        crc_d     = crc_q;
        stat_d    = stat_q;
        er_d      = er_q;
        ec_d      = ec_q;
        pay_d     = pay_q;
        status_d  = status_q;
        err_row_d = err_row_q;
        err_col_d = err_col_q;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    blk_d   = blk_in;
                    rp_d    = row_p_in;
                    cp_d    = col_p_in;
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                    state_d = S_SYND;
                end
            end
            S_SYND: begin
                acc_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (acc_last) state_d = S_CORR;
            end
            S_CORR: begin
                cnt_d   = '0;
                crc_d   = SEED;
                stat_d  = DS_CLEAN;
                er_d    = '0;
                ec_d    = '0;
                state_d = S_CRC;
                if (rs_one && cs_one) begin
                    blk_d  = blk_q ^ (DW'(1) << (int'(r_idx) * WIDTH + int'(c_idx)));
                    stat_d = DS_CORRECTED;
                    er_d   = r_idx;
                    ec_d   = c_idx;
                end else if (!fixable) begin
                    pay_d     = blk_q[PW-1:0];
                    status_d  = DS_UNCORR;
                    err_row_d = '0;
                    err_col_d = '0;
                    state_d   = S_DONE;
                end
            end
            S_CRC: begin
                crc_d = crc_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNTW'(NCH - 1)) begin
                    pay_d     = blk_q[PW-1:0];
                    status_d  = crc_bad ? DS_CRC_FAIL : stat_q;
                    err_row_d = crc_bad ? '0 : er_q;
                    err_col_d = crc_bad ? '0 : ec_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            blk_q     <= '0;
            rp_q      <= '0;
            cp_q      <= '0;
            crc_q     <= '0;
            stat_q    <= '0;
            er_q      <= '0;
            ec_q      <= '0;
            pay_q     <= '0;
            status_q  <= '0;
            err_row_q <= '0;
            err_col_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            blk_q     <= blk_d;
            rp_q      <= rp_d;
            cp_q      <= cp_d;
            crc_q     <= crc_d;
            stat_q    <= stat_d;
            er_q      <= er_d;
            ec_q      <= ec_d;
            pay_q     <= pay_d;
            status_q  <= status_d;
            err_row_q <= err_row_d;
            err_col_q <= err_col_d;
        end
    end

    assign busy        = (state_q == S_SYND) || (state_q == S_CORR) ||
                         (state_q == S_CRC);
    assign done        = (state_q == S_DONE);
    assign payload_out = pay_q;
    assign status      = status_q;
    assign err_row     = err_row_q;
    assign err_col     = err_col_q;

endmodule

// File: tb/tb_dl_fec_dec_engine.sv
// Directed + randomized bench for the payload (8x8, CRC-8) and
// header (4x4, CRC-4) decoder instances against a division-based model.
module tb_dl_fec_dec_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_a = 1'b0;
    logic [63:0] blk_a = '0;
    logic [7:0]  rp_a = '0, cp_a = '0;
    logic        busy_a, done_a;
    logic [55:0] pay_a;
    logic [1:0]  stat_a;
    logic [2:0]  er_a, ec_a;

    logic        start_b = 1'b0;
    logic [15:0] blk_b = '0;
    logic [3:0]  rp_b = '0, cp_b = '0;
    logic        busy_b, done_b;
    logic [11:0] pay_b;
    logic [1:0]  stat_b;
    logic [1:0]  er_b, ec_b;

    int checks = 0;
    int fails  = 0;
    logic [1:0] prev_st_a = 2'd0;

    always #5 clk = ~clk;

    dl_fec_dec_engine u_a (
        .clk(clk), .rst(rst), .start(start_a), .blk_in(blk_a),
        .row_p_in(rp_a), .col_p_in(cp_a), .busy(busy_a), .done(done_a),
        .payload_out(pay_a), .status(stat_a), .err_row(er_a), .err_col(ec_a)
    );

    dl_fec_dec_engine #(
        .WIDTH(4), .DEPTH(4), .CRC_WIDTH(4), .POLY(4'h3), .SEED(4'h0),
        .XOR_OPS(4)
    ) u_b (
        .clk(clk), .rst(rst), .start(start_b), .blk_in(blk_b),
        .row_p_in(rp_b), .col_p_in(cp_b), .busy(busy_b), .done(done_b),
        .payload_out(pay_b), .status(stat_b), .err_row(er_b), .err_col(ec_b)
    );

    typedef struct {
        logic [1:0]  st;
        logic [63:0] pay;
        int          er;
        int          ec;
        int          lat;
    } res_t;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC as the remainder of payload * x^cw divided by the generator
    function automatic logic [7:0] crc_ref(input logic [63:0] pay, input int pw,
                                           input int cw, input logic [8:0] gen);
        logic [71:0] m;
        m = 72'(pay) << cw;
        for (int i = pw + cw - 1; i >= cw; i--)
            if (m[i]) m = m ^ (72'(gen) << (i - cw));
        return m[7:0] & 8'((1 << cw) - 1);
    endfunction

    function automatic logic [63:0] mk(input logic [63:0] pay, input int pw,
                                       input int cw, input logic [8:0] gen);
        return (64'(crc_ref(pay, pw, cw, gen)) << pw) | pay;
    endfunction

    function automatic logic [7:0] rowpar(input logic [63:0] b, input int w,
                                          input int d);
        logic [7:0] p = '0;
        for (int r = 0; r < d; r++)
            for (int c = 0; c < w; c++) p[r] ^= b[r*w+c];
        return p;
    endfunction

    function automatic logic [7:0] colpar(input logic [63:0] b, input int w,
                                          input int d);
        logic [7:0] p = '0;
        for (int c = 0; c < w; c++)
            for (int r = 0; r < d; r++) p[c] ^= b[r*w+c];
        return p;
    endfunction

    function automatic res_t model(input logic [63:0] blk, input logic [7:0] rp,
                                   input logic [7:0] cp, input int w, input int d,
                                   input int cw, input logic [8:0] gen, input int xo);
        res_t o;
        int nr, nc, fr, fc, pw;
        logic p;
        logic [63:0] b;
        b = blk; nr = 0; nc = 0; fr = 0; fc = 0; pw = w*d - cw;
        for (int r = 0; r < d; r++) begin
            p = rp[r];
            for (int c = 0; c < w; c++) p ^= b[r*w+c];
            if (p) begin nr++; fr = r; end
        end
        for (int c = 0; c < w; c++) begin
            p = cp[c];
            for (int r = 0; r < d; r++) p ^= b[r*w+c];
            if (p) begin nc++; fc = c; end
        end
        o.er = 0; o.ec = 0; o.lat = d + pw/xo + 2;
        if (nr == 1 && nc == 1) begin
            b[fr*w+fc] = ~b[fr*w+fc];
            o.st = 2'd1; o.er = fr; o.ec = fc;
        end else if (nr <= 1 && nc <= 1) begin
            o.st = 2'd0;
        end else begin
            o.st = 2'd2; o.lat = d + 2;
        end
        o.pay = b & ((64'd1 << pw) - 1);
        if (o.st != 2'd2 &&
            crc_ref(o.pay, pw, cw, gen) != 8'((b >> pw) & ((64'd1 << cw) - 1))) begin
            o.st = 2'd3; o.er = 0; o.ec = 0;
        end
        return o;
    endfunction

    task automatic run_a(input string tag, input logic [63:0] b,
                         input logic [7:0] rp, input logic [7:0] cp, input bit poke);
        res_t e;
        int cyc;
        e = model(b, rp, cp, 8, 8, 8, 9'h107, 8);
        @(posedge clk); #1;
        start_a = 1'b1; blk_a = b; rp_a = rp; cp_a = cp;
        @(posedge clk); #1;
        start_a = 1'b0; blk_a = {$urandom(), $urandom()};
        rp_a = 8'($urandom()); cp_a = 8'($urandom());
        cyc = 1;
        chk({tag, ".busy1"}, 64'(busy_a), 64'd1);
        chk({tag, ".hold"}, 64'(stat_a), 64'(prev_st_a));
        while (!done_a && cyc < 40) begin
            if (poke && cyc == 3) start_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0;
            cyc++;
        end
        chk({tag, ".lat"}, 64'(cyc), 64'(e.lat));
        chk({tag, ".busy0"}, 64'(busy_a), 64'd0);
        chk({tag, ".status"}, 64'(stat_a), 64'(e.st));
        chk({tag, ".payload"}, 64'(pay_a), e.pay);
        chk({tag, ".err_row"}, 64'(er_a), 64'(e.er));
        chk({tag, ".err_col"}, 64'(ec_a), 64'(e.ec));
        prev_st_a = e.st;
        start_a = 1'b1; blk_a = {$urandom(), $urandom()};
        @(posedge clk); #1;
        start_a = 1'b0;
        chk({tag, ".doneidle"}, {62'd0, busy_a, done_a}, 64'd0);
    endtask

    task automatic run_b(input string tag, input logic [15:0] b,
                         input logic [3:0] rp, input logic [3:0] cp, input bit poke);
        res_t e;
        int cyc;
        e = model(64'(b), 8'(rp), 8'(cp), 4, 4, 4, 9'h013, 4);
        @(posedge clk); #1;
        start_b = 1'b1; blk_b = b; rp_b = rp; cp_b = cp;
        @(posedge clk); #1;
        start_b = 1'b0; blk_b = 16'($urandom());
        cyc = 1;
        while (!done_b && cyc < 40) begin
            if (poke && cyc == 2) start_b = 1'b1;
            @(posedge clk); #1;
            start_b = 1'b0;
            cyc++;
        end
        chk({tag, ".lat"}, 64'(cyc), 64'(e.lat));
        chk({tag, ".status"}, 64'(stat_b), 64'(e.st));
        chk({tag, ".payload"}, 64'(pay_b), e.pay);
        chk({tag, ".err"}, {60'd0, er_b, ec_b}, 64'({e.er[1:0], e.ec[1:0]}));
        @(posedge clk); #1;
        chk({tag, ".idle"}, {62'd0, busy_b, done_b}, 64'd0);
    endtask

    initial begin
        logic [63:0] b0, b1, bw;
        logic [15:0] h0, h1;
        int cyc, seen, md, k1, k2;

        #1;
        chk("rst.a", {pay_a, stat_a, er_a, ec_a, busy_a, done_a}, 64'd0);
        chk("rst.b", {46'd0, pay_b, stat_b, busy_b, done_b}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        b0 = mk(64'h00_01_02_03_04_05_06, 56, 8, 9'h107);
        run_a("t1.clean", b0, rowpar(b0, 8, 8), colpar(b0, 8, 8), 1'b0);
        b1 = b0 ^ (64'd1 << 29);
        run_a("t2.fix35", b1, rowpar(b0, 8, 8), colpar(b0, 8, 8), 1'b0);
        b1 = b0 ^ (64'd1 << 10) ^ (64'd1 << 45);
        run_a("t3.uncorr", b1, rowpar(b0, 8, 8), colpar(b0, 8, 8), 1'b1);
        run_a("t4.rowp", b0, rowpar(b0, 8, 8) ^ 8'h04, colpar(b0, 8, 8), 1'b0);
        b1 = b0 ^ (64'd1 << 56);
        run_a("t4.crcbit", b1, rowpar(b0, 8, 8), colpar(b0, 8, 8), 1'b0);
        bw = b0 ^ (64'h5A << 56);
        run_a("t5.crcfail", bw, rowpar(bw, 8, 8), colpar(bw, 8, 8), 1'b0);

        for (int i = 0; i < 24; i++) begin
            b0 = mk({8'd0, $urandom_range(0, 'hFFFFFF), $urandom()}, 56, 8, 9'h107);
            b1 = b0; bw = b0;
            md = $urandom_range(0, 4);
            k1 = $urandom_range(0, 63);
            k2 = $urandom_range(0, 63);
            if (md == 1) b1[k1] = ~b1[k1];
            if (md == 2) begin b1[k1] = ~b1[k1]; b1[k2] = ~b1[k2]; end
            if (md == 4) begin b1 = b0 ^ (64'(1 + $urandom_range(0, 254)) << 56); bw = b1; end
            if (md == 3)
                run_a("ra.par", b1, rowpar(bw, 8, 8) ^ 8'(1 << (k1 % 8)),
                      colpar(bw, 8, 8), 1'b0);
            else
                run_a("ra.rand", b1, rowpar(bw, 8, 8), colpar(bw, 8, 8), i[0]);
        end

        h0 = 16'(mk(64'hA53, 12, 4, 9'h013));
        run_b("t6.clean", h0, 4'(rowpar(64'(h0), 4, 4)), 4'(colpar(64'(h0), 4, 4)), 1'b0);

        @(posedge clk); #1;
        start_b = 1'b1; blk_b = h0;
        rp_b = 4'(rowpar(64'(h0), 4, 4)); cp_b = 4'(colpar(64'(h0), 4, 4));
        @(posedge clk); #1;
        start_b = 1'b0;
        cyc = 1;
        while (cyc < 5) begin @(posedge clk); #1; cyc++; end
        rst = 1'b1; #1;
        prev_st_a = 2'd0;
        chk("t6.rst.out", {46'd0, pay_b, stat_b, busy_b, done_b}, 64'd0);
        chk("t6.rst.err", {60'd0, er_b, ec_b}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done_b || busy_b) seen++;
        end
        chk("t6.rst.nodone", 64'(seen), 64'd0);
        run_b("t6.restart", h0, 4'(rowpar(64'(h0), 4, 4)), 4'(colpar(64'(h0), 4, 4)), 1'b0);
        run_b("t6.busystart", h0, 4'(rowpar(64'(h0), 4, 4)), 4'(colpar(64'(h0), 4, 4)), 1'b1);

        for (int i = 0; i < 12; i++) begin
            h0 = 16'(mk(64'($urandom_range(0, 'hFFF)), 12, 4, 9'h013));
            h1 = h0;
            md = $urandom_range(0, 2);
            k1 = $urandom_range(0, 15);
            k2 = $urandom_range(0, 15);
            if (md >= 1) h1[k1] = ~h1[k1];
            if (md == 2) h1[k2] = ~h1[k2];
            run_b("rb.rand", h1, 4'(rowpar(64'(h0), 4, 4)),
                  4'(colpar(64'(h0), 4, 4)), i[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
